// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front-end.
//   INST_W / ADDR_W  : instruction and address widths
//   PC_STEP          : byte distance between consecutive instruction words
//   fetch_entry_t    : one buffered instruction together with its PC
//   fetch_state_e    : fetch control states
//   align_pc()       : clears the byte-offset bits of a PC
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    DRAIN
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO used by the fetch unit, both as the
// instruction prefetch buffer and as the queue of in-flight request addresses.
//   clk, nrst  : clock and synchronous active-low reset
//   push       : write push_data at the tail (caller guarantees space, or a
//                simultaneous pop on a full FIFO)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; takes precedence over push and pop
//   head       : current head entry, read straight from storage registers
//   count      : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Pointer/count bookkeeping. On a full FIFO a push and a pop may share the
  // same slot: the head is read from mem_q this cycle and overwritten at the edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
// Issues in-order word requests to the instruction memory, buffers returned
// words with their PCs in a DEPTH-entry prefetch FIFO and hands them to the
// core over a valid/ready handshake. A redirect flushes the FIFO, restarts
// fetch at redirect_pc and discards every response still in flight.
//   clk, nrst                       : clock, synchronous active-low reset
//   imem_req_valid/addr/ready       : request channel (word-aligned byte address)
//   imem_rsp_valid/data             : response channel, in request order, never stalled
//   inst_valid/inst/inst_pc/ready   : instruction channel to the core
//   redirect/redirect_pc            : flush and refetch from redirect_pc (bits [1:0] ignored)
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_dropped
// counters (32-bit, wrapping) for delivered-to-FIFO and discarded responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH   = 4,
  parameter logic [ADDR_W-1:0] PC_INIT = 64'h0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]       CREDITS  = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RESET = align_pc(PC_INIT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW:0]       credits_used;
  logic              req_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] rsp_pc;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // DRAIN simply mirrors "stale responses still to be discarded".
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET:   state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
      RUN:     if (drop_cnt_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
      default: state_d = RESET;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Every buffered word and every in-flight request holds one FIFO slot, so
  // issuing only while their sum is below DEPTH makes FIFO overflow impossible.
  always_comb begin
    credits_used   = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = (state_q != RESET) && (credits_used < CREDITS);
  end

  assign imem_req_addr = fetch_pc_q;

  // ---------------- Datapath ----------------
  // A response is stale if older than the last redirect (drop_cnt) or if it
  // lands in the redirect cycle itself. On redirect every request still in
  // flight after this edge, including one issued now, becomes stale.
  always_comb begin
    req_fire         = imem_req_valid && imem_req_ready;
    pop              = inst_valid && inst_ready;
    rsp_drop         = imem_rsp_valid && (redirect || (drop_cnt_q != '0));
    push             = imem_rsp_valid && !rsp_drop;
    push_entry       = '{pc: rsp_pc, inst: imem_rsp_data};
    outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      drop_cnt_d = outstanding_next;
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_pc_q <= PC_RESET;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Prefetch buffer: flush on redirect wins over any same-cycle pop.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_inst_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_entry),
    .count     (count)
  );

  // In-flight address queue: its occupancy is the outstanding-request count
  // and its head is the PC of the next response. Never flushed, because stale
  // responses still arrive and must retire their entries.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_addr_queue (
    .clk       (clk),
    .nrst      (nrst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head      (rsp_pc),
    .count     (outstanding)
  );

  assign inst_valid = (count != '0);
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_dropped_q, stat_dropped_d;

  // Free-running wrapping event counters.
  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(push);
    stat_dropped_d = stat_dropped_q + 32'(rsp_drop);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural memory returns words in order after a per-request latency.
// The reference model tracks the expected fetch stream: issued addresses and
// delivered PCs both run consecutively from the last reset/redirect target,
// and a response is stale exactly when its request predates the latest redirect.
// Build with FETCH_STATS_EN defined to also check the statistics counters.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [63:0] PC_INIT = 64'h0;

  logic        clk;
  logic        nrst;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  fetch_unit #(
    .DEPTH   (DEPTH),
    .PC_INIT (PC_INIT)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pending[$];
  logic [63:0] delivered[$];
  int          cyc;
  int          cur_epoch;
  int          lat;
  logic [63:0] exp_pc;
  logic [63:0] exp_req_addr;
  int          model_fetched;
  int          model_dropped;
  int          n_cmp;
  int          n_mis;
  bit          obs_req_valid;
  bit          obs_inst_valid;
  bit          last_redirect;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_mis++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs and memory response at the negedge, check
  // outputs against the model, then advance the model to the next posedge.
  task automatic applyStimulus(input bit mem_rdy, input bit core_rdy,
                               input bit redir, input logic [63:0] rpc);
    req_t r;
    bit   req_fire;
    bit   rsp_now;
    @(negedge clk);
    imem_req_ready = mem_rdy;
    inst_ready     = core_rdy;
    redirect       = redir;
    redirect_pc    = rpc;
    rsp_now        = (pending.size() != 0) && (pending[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(pending[0].addr) : $urandom;

    obs_req_valid  = imem_req_valid;
    obs_inst_valid = inst_valid;

    if (last_redirect) checkOutput("post_redirect_inst_valid", inst_valid, 0);
`ifdef FETCH_STATS_EN
    checkOutput("stat_fetched", stat_fetched, 64'(model_fetched));
    checkOutput("stat_dropped", stat_dropped, 64'(model_dropped));
`endif
    if (imem_req_valid) begin
      checkOutput("req_addr", imem_req_addr, exp_req_addr);
      checkOutput("req_credit", pending.size() < DEPTH, 1);
    end
    if (inst_valid && core_rdy) begin
      checkOutput("inst_pc", inst_pc, exp_pc);
      checkOutput("inst_word", inst, mem_word(exp_pc));
      delivered.push_back(inst_pc);
      exp_pc = exp_pc + 64'd4;
    end

    req_fire = imem_req_valid && mem_rdy;
    if (req_fire) begin
      r.addr  = exp_req_addr;
      r.due   = cyc + lat;
      r.epoch = cur_epoch;
      pending.push_back(r);
      exp_req_addr = exp_req_addr + 64'd4;
    end
    if (rsp_now) begin
      r = pending.pop_front();
      if (redir || (r.epoch != cur_epoch)) model_dropped++;
      else model_fetched++;
    end
    if (redir) begin
      cur_epoch++;
      exp_pc       = rpc & ~64'h3;
      exp_req_addr = rpc & ~64'h3;
    end
    last_redirect = redir;
    cyc++;
    @(posedge clk);
  endtask

  // One-cycle reset of DUT and memory together, checking reset values.
  task automatic applyReset();
    @(negedge clk);
    nrst           = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    pending.delete();
    delivered.delete();
    cur_epoch++;
    exp_pc        = PC_INIT;
    exp_req_addr  = PC_INIT;
    model_fetched = 0;
    model_dropped = 0;
    last_redirect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", imem_req_valid, 0);
    checkOutput("rst_req_addr", imem_req_addr, PC_INIT);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
`ifdef FETCH_STATS_EN
    checkOutput("rst_stat_fetched", stat_fetched, 0);
    checkOutput("rst_stat_dropped", stat_dropped, 0);
`endif
    nrst = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int idx;
    n_cmp     = 0;
    n_mis     = 0;
    cyc       = 0;
    cur_epoch = 0;
    lat       = 1;
    nrst      = 1'b0;

    // Scenario 1: k=1, core always ready; first word visible two cycles in.
    applyReset();
    lat = 1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      if (i == 0) checkOutput("s1_first_req_valid", obs_req_valid, 1);
      checkOutput("s1_inst_valid", obs_inst_valid, (i >= 2));
    end

    // Scenario 2: core stalls, FIFO fills to DEPTH and issue stops.
    applyReset();
    lat = 1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("s2_req_valid_full", obs_req_valid, 0);
    checkOutput("s2_inst_valid_full", obs_inst_valid, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput("s2_release_valid", obs_inst_valid, 1);
    end
    checkOutput("s2_delivered", delivered.size(), 5);

    // Scenario 3: k=3, redirect after three requests; all three dropped.
    applyReset();
    lat = 3;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h100);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("s3_delivered_any", delivered.size() > 0, 1);
    if (delivered.size() > 0) checkOutput("s3_first_pc", delivered[0], 64'h100);
`ifdef FETCH_STATS_EN
    #1;
    checkOutput("s3_stat_dropped", stat_dropped, 3);
`endif

    // Scenario 4: redirect coinciding with req_fire and rsp_fire.
    applyReset();
    lat = 1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h2000);
    checkOutput("s4_req_fire_in_redirect", obs_req_valid, 1);
    idx = delivered.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("s4_delivered_any", delivered.size() > idx, 1);
    if (delivered.size() > idx) checkOutput("s4_first_pc", delivered[idx], 64'h2000);

    // Scenario 5: redirect to the top of the address space, PC wraps to 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    idx = delivered.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("s5_delivered_two", delivered.size() > idx + 1, 1);
    if (delivered.size() > idx + 1) begin
      checkOutput("s5_top_pc", delivered[idx], 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("s5_wrap_pc", delivered[idx+1], 64'h0);
    end

    // Scenario 6: mid-stream reset with buffered and in-flight words.
    lat = 2;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("s6_req_valid_after_reset", obs_req_valid, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("s6_delivered_any", delivered.size() > 0, 1);

    // Random phase: random stalls, latencies, unaligned redirects, one reset.
    applyReset();
    idx = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        idx = idx + delivered.size();
        applyReset();
      end
      lat = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 39) == 0, {$urandom, $urandom});
    end
    idx = idx + delivered.size();
    checkOutput("rand_progress", idx > 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
